// File: rtl/hir_mem_pkg.sv
// Shared types and helpers for the HIR memref responder: controller state
// encoding and an elaboration-time ceil(log2) used to size counters and indices.
package hir_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DUMP  = 3'd4
  } state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hir_skid_buf.sv
// Two-entry valid/ready buffer. Upstream ready depends only on occupancy, so the
// downstream ready never reaches the producer combinationally.
module hir_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] d0_q, d0_d;
  logic [WIDTH-1:0] d1_q, d1_d;
  logic             push, pop;

  always_comb begin
    cnt_d = cnt_q;
    d0_d  = d0_q;
    d1_d  = d1_q;
    push  = s_valid && (cnt_q != 2'd2);
    pop   = (cnt_q != 2'd0) && m_ready;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) d0_d = s_data;
        else               d1_d = s_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        // Head keeps its value when the last entry leaves, avoiding a stale
        // second slot leaking onto m_data.
        if (cnt_q == 2'd2) d0_d = d1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          d0_d = s_data;
        end else begin
          d0_d = d1_q;
          d1_d = s_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      d0_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      d0_q  <= d0_d;
    end
  end

  always_ff @(posedge clk) begin
    d1_q <= d1_d;
  end

  assign s_ready = (cnt_q != 2'd2);
  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = d0_q;

endmodule

// File: rtl/hir_memref_responder.sv
// Memory-side responder for an HIR kernel memref argument: host load, kernel
// start pulse, read-first RAM service during RUN, then an in-order dump.
module hir_memref_responder
  import hir_mem_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SIZE   = 64,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              tstart,
  input  logic              kernel_done,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              busy,
  output logic              err
);

  localparam int                CNT_W  = clog2(SIZE + 1);
  localparam int                IDX_W  = (clog2(SIZE) < 1) ? 1 : clog2(SIZE);
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(SIZE - 1);
  localparam logic [CNT_W-1:0]  SIZE_C = CNT_W'(SIZE);
  localparam logic [ADDR_W:0]   SIZE_A = (ADDR_W + 1)'(SIZE);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] fet_q, fet_d;
  logic             err_q, err_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  logic [WIDTH-1:0] mem_q [SIZE];
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  logic             rd_ok, wr_ok;
  logic [IDX_W-1:0] rd_idx, wr_idx, fet_idx;
  logic             skid_in_valid, skid_in_ready, dump_push;
  logic             skid_out_valid, dump_pop;
  logic [WIDTH-1:0] skid_out_data;

  // Range checks keep the full address width so out-of-range addresses never alias.
  assign rd_ok   = ({1'b0, rd_addr} < SIZE_A);
  assign wr_ok   = ({1'b0, wr_addr} < SIZE_A);
  assign rd_idx  = rd_addr[IDX_W-1:0];
  assign wr_idx  = wr_addr[IDX_W-1:0];
  assign fet_idx = fet_q[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      fet_q      <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fet_q      <= fet_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fet_d      = fet_q;
    err_d      = err_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = ST_START;
        end
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (rd_en) begin
          rd_valid_d = 1'b1;
          rd_data_d  = rd_ok ? mem_q[rd_idx] : '0;
        end
        if (kernel_done) begin
          state_d = ST_DUMP;
          cnt_d   = '0;
          fet_d   = '0;
        end
      end
      ST_DUMP: begin
        if (dump_push) fet_d = fet_q + 1'b1;
        if (dump_pop) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Kernel strobes are only legal in RUN, and only in range there.
    if (state_q == ST_RUN) begin
      if ((rd_en && !rd_ok) || (wr_en && !wr_ok)) err_d = 1'b1;
    end else if (rd_en || wr_en) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    in_ready      = (state_q == ST_LOAD);
    tstart        = (state_q == ST_START);
    busy          = (state_q != ST_IDLE);
    mem_we        = 1'b0;
    mem_waddr     = cnt_q[IDX_W-1:0];
    mem_wdata     = in_data;
    skid_in_valid = (state_q == ST_DUMP) && (fet_q < SIZE_C);
    dump_push     = skid_in_valid && skid_in_ready;
    dump_pop      = (state_q == ST_DUMP) && skid_out_valid && out_ready;
    if (state_q == ST_LOAD && in_valid) begin
      mem_we = 1'b1;
    end else if (state_q == ST_RUN && wr_en && wr_ok) begin
      mem_we    = 1'b1;
      mem_waddr = wr_idx;
      mem_wdata = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  hir_skid_buf #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (skid_in_valid),
    .s_ready (skid_in_ready),
    .s_data  (mem_q[fet_idx]),
    .m_valid (skid_out_valid),
    .m_ready (out_ready),
    .m_data  (skid_out_data)
  );

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign out_valid = skid_out_valid;
  assign out_data  = skid_out_data;
  assign err       = err_q;

endmodule

// File: tb/tb_hir_memref_responder.sv
// Directed bench for hir_memref_responder: load, kernel access table, dump with
// backpressure, and reset in the middle of a load.
module tb_hir_memref_responder;

  localparam int WIDTH  = 32;
  localparam int SIZE   = 64;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_start, in_valid, in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              tstart, kernel_done;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              rd_en, wr_en, rd_valid;
  logic [WIDTH-1:0]  rd_data, wr_data;
  logic              out_valid, out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              busy, err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_mem [SIZE];

  typedef struct {
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              exp_rv;
    logic [WIDTH-1:0]  exp_rd;
    logic              exp_err;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  hir_memref_responder #(
    .WIDTH(WIDTH), .SIZE(SIZE), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tstart(tstart), .kernel_done(kernel_done),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    chk({tag, "_tstart"},    32'(tstart),    32'd0);
    chk({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
    chk({tag, "_rd_data"},   rd_data,        32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"},  out_data,       32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_err"},       32'(err),       32'd0);
  endtask

  task automatic load_words(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      if (i == 20) begin
        in_valid = 1'b0;
        tick();
        tick();
        chk("load_stall_ready", 32'(in_ready), 32'd1);
      end
      in_valid = 1'b1;
      in_data  = 32'(base + i);
      chk($sformatf("load_ready%0d", i), 32'(in_ready), 32'd1);
      chk($sformatf("load_no_tstart%0d", i), 32'(tstart), 32'd0);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic dump_check(input bit bp);
    int k;
    int cyc;
    int first;
    bit hold;
    logic [WIDTH-1:0] prev;
    logic [3:0] pat;
    k = 0; cyc = 0; first = -1; hold = 1'b0; prev = '0;
    pat = 4'b1001;
    while (k < SIZE && cyc < 1000) begin
      out_ready = bp ? pat[cyc % 4] : 1'b1;
      if (hold) begin
        chk("dump_hold_valid", 32'(out_valid), 32'd1);
        chk("dump_hold_data", out_data, prev);
      end
      if (out_valid) begin
        if (first < 0) first = cyc;
        chk($sformatf("dump_word%0d", k), out_data, exp_mem[k]);
      end
      hold = out_valid && !out_ready;
      prev = out_data;
      if (out_valid && out_ready) k++;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    chk("dump_count", 32'(k), 32'(SIZE));
    chk("dump_first_latency_ok", 32'(first >= 0 && first <= 2), 32'd1);
    chk("dump_end_out_valid", 32'(out_valid), 32'd0);
    chk("dump_end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = '0;
    kernel_done = 1'b0; rd_addr = '0; rd_en = 1'b0; wr_addr = '0;
    wr_en = 1'b0; wr_data = '0; out_ready = 1'b0;

    vecs[0]  = '{1'b1, 8'd5,  1'b0, 8'd0,   32'h0,      1'b1, 32'd6,      1'b0};
    vecs[1]  = '{1'b1, 8'd0,  1'b0, 8'd0,   32'h0,      1'b1, 32'd1,      1'b0};
    vecs[2]  = '{1'b1, 8'd1,  1'b0, 8'd0,   32'h0,      1'b1, 32'd2,      1'b0};
    vecs[3]  = '{1'b1, 8'd2,  1'b0, 8'd0,   32'h0,      1'b1, 32'd3,      1'b0};
    vecs[4]  = '{1'b1, 8'd3,  1'b0, 8'd0,   32'h0,      1'b1, 32'd4,      1'b0};
    vecs[5]  = '{1'b1, 8'd3,  1'b1, 8'd3,   32'h1234,   1'b1, 32'd4,      1'b0};
    vecs[6]  = '{1'b1, 8'd3,  1'b0, 8'd0,   32'h0,      1'b1, 32'h1234,   1'b0};
    vecs[7]  = '{1'b0, 8'd0,  1'b0, 8'd0,   32'h0,      1'b0, 32'h0,      1'b0};
    vecs[8]  = '{1'b1, 8'd64, 1'b0, 8'd0,   32'h0,      1'b1, 32'h0,      1'b1};
    vecs[9]  = '{1'b0, 8'd0,  1'b1, 8'd200, 32'hdead,   1'b0, 32'h0,      1'b1};
    vecs[10] = '{1'b1, 8'd8,  1'b0, 8'd0,   32'h0,      1'b1, 32'd9,      1'b1};
    vecs[11] = '{1'b1, 8'd63, 1'b0, 8'd0,   32'h0,      1'b1, 32'd64,     1'b1};

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("idle_wr_err", 32'(err), 32'd1);
    chk("idle_wr_busy", 32'(busy), 32'd0);

    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("load_start_err_clear", 32'(err), 32'd0);
    chk("load_start_busy", 32'(busy), 32'd1);

    load_words(1, SIZE);
    for (int i = 0; i < SIZE; i++) exp_mem[i] = 32'(i + 1);
    chk("start_tstart", 32'(tstart), 32'd1);
    chk("start_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("run_tstart_low", 32'(tstart), 32'd0);

    for (int v = 0; v < 12; v++) begin
      rd_en   = vecs[v].rd_en;
      rd_addr = vecs[v].rd_addr;
      wr_en   = vecs[v].wr_en;
      wr_addr = vecs[v].wr_addr;
      wr_data = vecs[v].wr_data;
      tick();
      chk($sformatf("vec%0d_rd_valid", v), 32'(rd_valid), 32'(vecs[v].exp_rv));
      if (vecs[v].exp_rv) chk($sformatf("vec%0d_rd_data", v), rd_data, vecs[v].exp_rd);
      chk($sformatf("vec%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
    end
    rd_en = 1'b0; wr_en = 1'b0;
    exp_mem[3] = 32'h1234;

    rd_en = 1'b1; rd_addr = 8'd10; kernel_done = 1'b1;
    tick();
    rd_en = 1'b0; kernel_done = 1'b0;
    chk("done_read_valid", 32'(rd_valid), 32'd1);
    chk("done_read_data", rd_data, 32'd11);
    dump_check(1'b1);
    chk("err_sticky", 32'(err), 32'd1);

    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("reload_err_clear", 32'(err), 32'd0);
    load_words(500, 10);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", 32'(busy), 32'd0);

    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_words(100, SIZE);
    for (int i = 0; i < SIZE; i++) exp_mem[i] = 32'(100 + i);
    chk("reload_tstart", 32'(tstart), 32'd1);
    tick();
    kernel_done = 1'b1;
    tick();
    kernel_done = 1'b0;
    dump_check(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
